// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V data-memory controller: load/store funct3 codes,
// the controller state type and small decode helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Low address bits that must be zero for an aligned access of this size.
    function automatic logic [1:0] align_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_ctrl_if.sv
// Request/response handshake bus between the MEM stage (master) and the data memory (slave).
interface riscv_dmem_ctrl_if #(parameter int ADDR_WIDTH = 32);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_funct3, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_funct3, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/riscv_dmem_lane_align.sv
// Byte-lane steering for RV32I sub-word accesses: store byte enables and shifted data,
// plus sign/zero extension of the selected load lane.
module riscv_dmem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [15:0] rsh;

    always_comb begin
        be        = 4'b0000;
        rdata_ext = '0;
        rsh       = 16'(rword >> {lane, 3'b000});
        wdata_sh  = wdata << {lane, 3'b000};
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << lane;
                rdata_ext = {{24{rsh[7]}}, rsh[7:0]};
            end
            F3_H: begin
                be        = 4'b0011 << lane;
                rdata_ext = {{16{rsh[15]}}, rsh};
            end
            F3_W: begin
                be        = 4'b1111;
                rdata_ext = rword;
            end
            F3_BU:   rdata_ext = {24'b0, rsh[7:0]};
            F3_HU:   rdata_ext = {16'b0, rsh};
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data memory with valid/ready handshakes, WAIT_CYCLES latency and RV32I sub-word access.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module riscv_dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    riscv_dmem_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_ready, accept, commit;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic                  op_we, op_err, range_err, align_err;
    logic [2:0]            op_f3;
    logic [31:0]           op_wdata;
    logic [1:0]            lane;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            be;
    logic [31:0]           wdata_sh, rdata_ext;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready      = (state_q == IDLE) || (state_q == RESP && bus.resp_ready);
    assign accept         = bus.req_valid && req_ready;
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // With zero wait states the commit happens on the accepting edge, so the
    // operands come straight from the bus rather than the request latch.
    assign commit = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);

    always_comb begin
        op_addr   = accept ? bus.req_addr   : addr_q;
        op_we     = accept ? bus.req_we     : we_q;
        op_f3     = accept ? bus.req_funct3 : f3_q;
        op_wdata  = accept ? bus.req_wdata  : wdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        align_err = |(op_addr[1:0] & align_mask(op_f3));
        lane      = op_addr[1:0];
`else
        align_err = 1'b0;
        lane      = op_addr[1:0] & ~align_mask(op_f3);
`endif
        range_err = (op_addr >> (IDX_W + 2)) != '0;
        idx       = op_addr[IDX_W+1:2];
        op_err    = range_err || align_err || !f3_legal(op_we, op_f3);
    end

    riscv_dmem_lane_align u_align (
        .funct3    (op_f3),
        .lane      (lane),
        .wdata     (op_wdata),
        .rword     (mem[idx]),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            addr_d  = bus.req_addr;
            we_d    = bus.req_we;
            f3_d    = bus.req_funct3;
            wdata_d = bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_CYCLES - 1);
            end
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == 4'd0) state_d = RESP;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                RESP:    if (bus.resp_ready) state_d = IDLE;
                default: ;
            endcase
        end
        if (commit) begin
            err_d   = op_err;
            rdata_d = (op_err || op_we) ? 32'd0 : rdata_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is never cleared; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (commit && op_we && !op_err && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl: one instance with WAIT_CYCLES=0 and one with 3, checked against a byte-array model.
module tb_riscv_dmem_ctrl;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  t_valid, t_rready;
    logic [31:0] t_addr, t_wdata;
    logic        t_we;
    logic [2:0]  t_f3;

    riscv_dmem_ctrl_if #(.ADDR_WIDTH(32)) if0 ();
    riscv_dmem_ctrl_if #(.ADDR_WIDTH(32)) if3 ();

    assign if0.req_valid  = t_valid[0];
    assign if0.resp_ready = t_rready[0];
    assign if0.req_addr   = t_addr;
    assign if0.req_we     = t_we;
    assign if0.req_funct3 = t_f3;
    assign if0.req_wdata  = t_wdata;
    assign if3.req_valid  = t_valid[1];
    assign if3.resp_ready = t_rready[1];
    assign if3.req_addr   = t_addr;
    assign if3.req_we     = t_we;
    assign if3.req_funct3 = t_f3;
    assign if3.req_wdata  = t_wdata;

    riscv_dmem_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    riscv_dmem_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .bus(if3.slave));

    logic        ov [2];
    logic        ory[2];
    logic        oe [2];
    logic [31:0] ord[2];
    assign ov[0] = if0.resp_valid;  assign ov[1] = if3.resp_valid;
    assign ory[0] = if0.req_ready;  assign ory[1] = if3.req_ready;
    assign oe[0] = if0.resp_err;    assign oe[1] = if3.resp_err;
    assign ord[0] = if0.resp_rdata; assign ord[1] = if3.resp_rdata;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] mdl [2][1024];

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference: byte-addressed memory, accesses of 1/2/4 bytes little-endian.
    task automatic model(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int size, ad;
        logic [31:0] v;
        rd = 32'd0;
        e  = 1'b0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
        if (a >= 32'd1024) e = 1'b1;
        ad = int'(a[9:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (ad % size != 0) e = 1'b1;
`else
        ad = ad - ad % size;
`endif
        if (e) return;
        if (we) begin
            for (int i = 0; i < size; i++) mdl[d][ad+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[d][ad+i];
            case (f3)
                3'd0:    rd = 32'($signed(v[7:0]));
                3'd1:    rd = 32'($signed(v[15:0]));
                default: rd = v;
            endcase
        end
    endtask

    task automatic xact(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] got, output logic got_err);
        logic        e;
        logic [31:0] rd;
        int          w;
        w = (d == 1) ? 3 : 0;
        t_we = we; t_f3 = f3; t_addr = a; t_wdata = wd;
        t_valid[d]  = 1'b1;
        t_rready[d] = (hold == 0);
        #1 check("req_ready_at_accept", 32'(ory[d]), 32'd1);
        model(d, we, f3, a, wd, e, rd);
        for (int i = 1; i <= w + 1; i++) begin
            @(negedge clk);
            if (i == 1) t_valid[d] = 1'b0;
            if (i <= w) begin
                check("wait_resp_valid", 32'(ov[d]), 32'd0);
                check("wait_req_ready", 32'(ory[d]), 32'd0);
            end
        end
        check("resp_valid", 32'(ov[d]), 32'd1);
        check("resp_err", 32'(oe[d]), 32'(e));
        check("resp_rdata", ord[d], rd);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(ov[d]), 32'd1);
            check("hold_rdata", ord[d], rd);
            check("hold_req_ready", 32'(ory[d]), 32'd0);
        end
        t_rready[d] = 1'b1;
        got     = ord[d];
        got_err = oe[d];
    endtask

    initial begin
        logic [31:0] g;
        logic        ge;
        logic [31:0] ra;
        int          d, r;
        t_valid = 2'b00; t_rready = 2'b11;
        t_addr = '0; t_wdata = '0; t_we = 1'b0; t_f3 = 3'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_req_ready", 32'(ory[k]), 32'd1);
            check("rst_resp_valid", 32'(ov[k]), 32'd0);
            check("rst_rdata", ord[k], 32'd0);
            check("rst_err", 32'(oe[k]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++)
            for (int wi = 0; wi < 16; wi++)
                xact(k, 1'b1, F3_W, 32'(wi * 4), $urandom, 0, g, ge);

        for (int k = 0; k < 2; k++) begin
            xact(k, 1'b1, F3_W,  32'h64, 32'h12345678, 0, g, ge);
            check("sw_rdata_zero", g, 32'd0);
            xact(k, 1'b0, F3_W,  32'h64, 32'd0, 0, g, ge);
            check("lw_64", g, 32'h12345678);
            xact(k, 1'b1, F3_B,  32'h65, 32'hAB, 0, g, ge);
            xact(k, 1'b0, F3_B,  32'h65, 32'd0, 0, g, ge);
            check("lb_65", g, 32'hFFFFFFAB);
            xact(k, 1'b0, F3_BU, 32'h65, 32'd0, 0, g, ge);
            check("lbu_65", g, 32'h000000AB);
            xact(k, 1'b0, F3_W,  32'h64, 32'd0, 0, g, ge);
            check("lw_64_merged", g, 32'h1234AB78);
            xact(k, 1'b0, F3_H,  32'h67, 32'd0, 0, g, ge);
`ifdef DMEM_MISALIGN_TRAP_EN
            check("lh_67_err", 32'(ge), 32'd1);
            check("lh_67_rdata", g, 32'd0);
`else
            check("lh_67_err", 32'(ge), 32'd0);
            check("lh_67_rdata", g, 32'h00001234);
`endif
            xact(k, 1'b0, F3_W, 32'h400, 32'd0, 0, g, ge);
            check("lw_400_err", 32'(ge), 32'd1);
            xact(k, 1'b1, F3_B, 32'h400, 32'h5A, 0, g, ge);
            check("sb_400_err", 32'(ge), 32'd1);
            // Drain so the held request starts from IDLE, then overlap both handshakes.
            @(negedge clk);
            xact(k, 1'b0, F3_W,  32'h64, 32'd0, 5, g, ge);
            xact(k, 1'b0, F3_HU, 32'h64, 32'd0, 0, g, ge);
            check("lhu_64_b2b", g, 32'h0000AB78);
        end

        repeat (120) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            if (r == 0)      ra = 32'h400 + $urandom_range(0, 63);
            else if (r == 1) ra = $urandom | 32'h400;
            else             ra = $urandom_range(0, 63);
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
            xact(d, 1'($urandom), 3'($urandom), ra, $urandom, 0, g, ge);
        end

        // Reset in the middle of a pending store on the wait-state instance.
        @(negedge clk);
        @(negedge clk);
        t_we = 1'b1; t_f3 = F3_W; t_addr = 32'h10; t_wdata = 32'hDEADBEEF;
        t_valid[1] = 1'b1;
        @(negedge clk);
        t_valid[1] = 1'b0;
        check("mid_wait_valid", 32'(ov[1]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(ory[1]), 32'd1);
        check("mid_rst_resp_valid", 32'(ov[1]), 32'd0);
        check("mid_rst_rdata", ord[1], 32'd0);
        check("mid_rst_err", 32'(oe[1]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_still_idle", 32'(ov[1]), 32'd0);
        xact(1, 1'b0, F3_W, 32'h10, 32'd0, 0, g, ge);
        check("no_commit_after_rst", 32'(g == 32'hDEADBEEF), 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
